// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the four-bank ALU responder. Holds the
//                command and response encodings, the per-bank input and
//                output packet structs, the bank FSM state encoding and the
//                datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    NO_COMMAND = 2'd0,
    ADD        = 2'd1,
    SUBTRACT   = 2'd2,
    SHIFT_LEFT = 2'd3
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    ERROR       = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t          command;
    logic [DATA_WIDTH-1:0]   data1;
    logic [DATA_WIDTH-1:0]   data2;
  } input_packet_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    response_names_t         response;
  } output_packet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXECUTE = 2'd1,
    RESPOND = 2'd2
  } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bank
//  Description : One independent ALU bank. Accepts a command in IDLE,
//                counts down the command latency in EXECUTE, registers the
//                result, then emits a one-cycle response pulse in RESPOND.
//  Ports       : clock         - posedge clock
//                reset         - asynchronous, active-low
//                input_packet  - command, data1, data2 (sampled in IDLE only)
//                output_packet - registered result data and response
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bank
  import alu_pkg::*;
#(
  parameter int ADD_LATENCY   = 2,
  parameter int SUB_LATENCY   = 2,
  parameter int SHIFT_LATENCY = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  input_packet_t  input_packet,
  output output_packet_t output_packet
);

  bank_state_t           state;
  command_names_t        cmd;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [3:0]            count;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] res_data;
  response_names_t       res_resp;

  // Counter preload: latency-1 so that a result lands exactly L edges
  // after acceptance.
  function automatic logic [3:0] load_count(input command_names_t c);
    case (c)
      ADD:        load_count = 4'(ADD_LATENCY - 1);
      SUBTRACT:   load_count = 4'(SUB_LATENCY - 1);
      SHIFT_LEFT: load_count = 4'(SHIFT_LATENCY - 1);
      default:    load_count = 4'd0;
    endcase
  endfunction

  // Result is computed from the captured operands only, so input changes
  // after acceptance cannot disturb it.
  always_comb begin
    sum      = {1'b0, op_a} + {1'b0, op_b};
    res_data = '0;
    res_resp = ERROR;
    case (cmd)
      ADD: begin
        res_data = sum[DATA_WIDTH-1:0];
        res_resp = sum[DATA_WIDTH] ? OVERFLOW : SUCCESS;
      end
      SUBTRACT: begin
        res_data = op_a - op_b;
        res_resp = (op_a < op_b) ? OVERFLOW : SUCCESS;
      end
      SHIFT_LEFT: begin
        // Shift amounts of 32 or more are rejected rather than wrapped.
        if (|op_b[DATA_WIDTH-1:5]) begin
          res_data = '0;
          res_resp = ERROR;
        end else begin
          res_data = op_a << op_b[4:0];
          res_resp = SUCCESS;
        end
      end
      default: begin
        res_data = '0;
        res_resp = ERROR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      cmd                    <= NO_COMMAND;
      op_a                   <= '0;
      op_b                   <= '0;
      count                  <= 4'd0;
      output_packet.data     <= '0;
      output_packet.response <= NO_RESPONSE;
    end else begin
      case (state)
        IDLE: begin
          if (input_packet.command != NO_COMMAND) begin
            cmd   <= input_packet.command;
            op_a  <= input_packet.data1;
            op_b  <= input_packet.data2;
            count <= load_count(input_packet.command);
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (count == 4'd0) begin
            output_packet.data     <= res_data;
            output_packet.response <= res_resp;
            state                  <= RESPOND;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESPOND: begin
          // Data is held; only the response pulse is retired.
          output_packet.response <= NO_RESPONSE;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_bank_responder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bank_responder
//  Description : Responder for the four-bank ALU packet interface. Wiring
//                only: one alu_bank per bank, fully independent.
//  Ports       : clock         - posedge clock
//                reset         - asynchronous, active-low
//                input_packet  - per-bank command packets
//                output_packet - per-bank registered result packets
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bank_responder
  import alu_pkg::*;
#(
  parameter int NUM_BANKS     = 4,
  parameter int ADD_LATENCY   = 2,
  parameter int SUB_LATENCY   = 2,
  parameter int SHIFT_LATENCY = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  input_packet_t  [NUM_BANKS-1:0] input_packet,
  output output_packet_t [NUM_BANKS-1:0] output_packet
);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    alu_bank #(
      .ADD_LATENCY   (ADD_LATENCY),
      .SUB_LATENCY   (SUB_LATENCY),
      .SHIFT_LATENCY (SHIFT_LATENCY)
    ) u_bank (
      .clock         (clock),
      .reset         (reset),
      .input_packet  (input_packet[i]),
      .output_packet (output_packet[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_bank_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_bank_responder
//  Description : Self-checking bench for alu_bank_responder. A timing-based
//                reference model predicts every bank's outputs each cycle
//                from acceptance times and plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_bank_responder;
  import alu_pkg::*;

  localparam int NB     = 4;
  localparam int L_ADD  = 2;
  localparam int L_SUB  = 2;
  localparam int L_SHL  = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  input_packet_t  [NB-1:0] in_pkt;
  output_packet_t [NB-1:0] out_pkt;

  alu_bank_responder #(
    .NUM_BANKS     (NB),
    .ADD_LATENCY   (L_ADD),
    .SUB_LATENCY   (L_SUB),
    .SHIFT_LATENCY (L_SHL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .input_packet  (in_pkt),
    .output_packet (out_pkt)
  );

  always #5 clock = ~clock;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state: expected outputs plus per-bank schedule.
  int          cyc = 0;
  int          free_at [NB];
  int          due_at  [NB];
  bit          busy    [NB];
  logic [31:0] pend_d  [NB];
  logic [1:0]  pend_r  [NB];
  logic [31:0] exp_d   [NB];
  logic [1:0]  exp_r   [NB];

  function automatic int lat(input logic [1:0] c);
    case (c)
      2'd1:    return L_ADD;
      2'd2:    return L_SUB;
      default: return L_SHL;
    endcase
  endfunction

  function automatic void ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic [1:0] r);
    logic [63:0] s;
    d = '0;
    r = 2'd3;
    case (c)
      2'd1: begin
        s = {32'd0, a} + {32'd0, b};
        d = s[31:0];
        r = (s > 64'h0000_0000_FFFF_FFFF) ? 2'd2 : 2'd1;
      end
      2'd2: begin
        d = a - b;
        r = (a < b) ? 2'd2 : 2'd1;
      end
      2'd3: begin
        if (b > 32'd31) begin
          d = '0;
          r = 2'd3;
        end else begin
          d = a << b;
          r = 2'd1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      free_at[b] = 0;
      due_at[b]  = 0;
      busy[b]    = 1'b0;
      exp_d[b]   = '0;
      exp_r[b]   = 2'd0;
    end
  endfunction

  function automatic void model_edge();
    cyc++;
    for (int b = 0; b < NB; b++) begin
      if (exp_r[b] != 2'd0) exp_r[b] = 2'd0;
      if (busy[b] && cyc == due_at[b]) begin
        exp_d[b] = pend_d[b];
        exp_r[b] = pend_r[b];
        busy[b]  = 1'b0;
      end
      if (cyc >= free_at[b] && in_pkt[b].command != NO_COMMAND) begin
        ref_op(in_pkt[b].command, in_pkt[b].data1, in_pkt[b].data2, pend_d[b], pend_r[b]);
        due_at[b]  = cyc + lat(in_pkt[b].command);
        free_at[b] = cyc + lat(in_pkt[b].command) + 2;
        busy[b]    = 1'b1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int b = 0; b < NB; b++) begin
      n_asserts++;
      assert (out_pkt[b].data === exp_d[b]) else begin
        n_fail++;
        $error("FAIL %s data bank%0d: observed %h expected %h", tag, b, out_pkt[b].data, exp_d[b]);
      end
      n_asserts++;
      assert (out_pkt[b].response === exp_r[b]) else begin
        n_fail++;
        $error("FAIL %s resp bank%0d: observed %0d expected %0d", tag, b, out_pkt[b].response, exp_r[b]);
      end
    end
  endtask

  // Directed spot check against constants written from the test plan.
  task automatic expect_bank(input string tag, input int b, input logic [31:0] d, input logic [1:0] r);
    n_asserts++;
    assert (out_pkt[b].data === d) else begin
      n_fail++;
      $error("FAIL %s data: observed %h expected %h", tag, out_pkt[b].data, d);
    end
    n_asserts++;
    assert (out_pkt[b].response === r) else begin
      n_fail++;
      $error("FAIL %s resp: observed %0d expected %0d", tag, out_pkt[b].response, r);
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge clock);
    if (reset) model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic set_cmd(input int b, input command_names_t c, input logic [31:0] d1, input logic [31:0] d2);
    in_pkt[b].command = c;
    in_pkt[b].data1   = d1;
    in_pkt[b].data2   = d2;
  endtask

  task automatic clear_cmds();
    for (int b = 0; b < NB; b++) in_pkt[b].command = NO_COMMAND;
  endtask

  // Asynchronous reset pulse: checked immediately, released a cycle later.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  int pulses;

  initial begin
    in_pkt = '0;
    model_reset();
    #1;
    check_all("reset_state");
    @(negedge clock);
    reset = 1'b1;

    // ADD 5+7 on bank 0, exact pulse timing
    set_cmd(0, ADD, 32'h5, 32'h7);
    tick("add_acc");
    clear_cmds();
    tick("add_n1");
    expect_bank("add_n1", 0, 32'h0, 2'd0);
    tick("add_n2");
    expect_bank("add_n2", 0, 32'h0000000C, 2'd1);
    tick("add_n3");
    expect_bank("add_n3", 0, 32'h0000000C, 2'd0);

    // All four banks in parallel with different commands
    set_cmd(0, SHIFT_LEFT, 32'h1, 32'h1F);
    set_cmd(1, ADD, 32'hFFFFFFFF, 32'h2);
    set_cmd(2, SUBTRACT, 32'h3, 32'h5);
    set_cmd(3, SUBTRACT, 32'h5, 32'h3);
    tick("par_acc");
    clear_cmds();
    tick("par_1");
    tick("par_2");
    expect_bank("add_ovf", 1, 32'h00000001, 2'd2);
    expect_bank("sub_ovf", 2, 32'hFFFFFFFE, 2'd2);
    expect_bank("sub_ok", 3, 32'h00000002, 2'd1);
    tick("par_3");
    tick("par_4");
    expect_bank("shl_31", 0, 32'h80000000, 2'd1);
    tick("par_5");

    // Shift by 32 is an error
    set_cmd(0, SHIFT_LEFT, 32'h1, 32'h20);
    tick("shl_err_acc");
    clear_cmds();
    repeat (3) tick("shl_err_wait");
    tick("shl_err_n4");
    expect_bank("shl_err", 0, 32'h0, 2'd3);
    tick("shl_err_n5");

    // Operand capture: data1 changes during EXECUTE
    set_cmd(1, ADD, 32'd10, 32'd20);
    tick("cap_acc");
    in_pkt[1].command = NO_COMMAND;
    in_pkt[1].data1   = 32'd999;
    tick("cap_1");
    tick("cap_2");
    expect_bank("capture", 1, 32'd30, 2'd1);
    tick("cap_3");

    // Held command re-executes at N+L+2
    set_cmd(2, SUBTRACT, 32'd9, 32'd4);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick("held");
      if (out_pkt[2].response != NO_RESPONSE) pulses++;
    end
    n_asserts++;
    assert (pulses === 2) else begin
      n_fail++;
      $error("FAIL held_pulses: observed %0d expected %0d", pulses, 2);
    end
    clear_cmds();
    repeat (4) tick("held_drain");

    // Reset mid-operation aborts the shift; a following ADD still works
    set_cmd(3, SHIFT_LEFT, 32'h3, 32'h2);
    tick("rst_acc");
    clear_cmds();
    tick("rst_1");
    tick("rst_2");
    reset_pulse("rst_mid");
    set_cmd(3, ADD, 32'd1, 32'd1);
    tick("rst_add_acc");
    clear_cmds();
    tick("rst_add_1");
    expect_bank("no_abort_pulse", 3, 32'h0, 2'd0);
    tick("rst_add_2");
    expect_bank("post_rst_add", 3, 32'h2, 2'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 2) == 0)
          in_pkt[b].command = command_names_t'($urandom_range(0, 3));
        else
          in_pkt[b].command = NO_COMMAND;
        in_pkt[b].data1 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
        in_pkt[b].data2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
      else tick("rand");
    end
    clear_cmds();
    repeat (6) tick("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_bank_responder.md
# alu_bank_responder

Responder side of the four-bank ALU packet interface. Each bank independently accepts a command packet (`command`, `data1`, `data2`) and executes it over a command-dependent number of cycles. It then returns a result packet (`data`, `response`) with a one-cycle response pulse. The block sits behind the bank-based initiators (test stimulus or upstream sequencers) and is the unit they wait on for a non-`NO_RESPONSE` result.

## Interface
- `NUM_BANKS`, 4: number of independent banks.
- `ADD_LATENCY`, 2: cycles from acceptance to response for `ADD` (legal 1..15).
- `SUB_LATENCY`, 2: same, for `SUBTRACT` (legal 1..15).
- `SHIFT_LATENCY`, 4: same, for `SHIFT_LEFT` (legal 1..15).

Ports:
- `clock`  in  1  single clock for the block; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `input_packet`  in  `input_packet_t [NUM_BANKS-1:0]`  per-bank command, data1 and data2.
- `output_packet`  out  `output_packet_t [NUM_BANKS-1:0]`  per-bank data and response, registered.

## Operation
- `command_names_t` (2 bits): `NO_COMMAND`=0, `ADD`=1, `SUBTRACT`=2, `SHIFT_LEFT`=3.
- `response_names_t` (2 bits): `NO_RESPONSE`=0, `SUCCESS`=1, `OVERFLOW`=2, `ERROR`=3.
- Per-bank FSM states:
  - `IDLE`: if `command != NO_COMMAND`, capture command, data1 and data2, load counter = latency-1, and go to `EXECUTE`.
  - `EXECUTE`: if counter==0, register the result and go to `RESPOND`; otherwise decrement the counter.
  - `RESPOND`: clear the response to `NO_RESPONSE`, hold data, and go to `IDLE`.
- Commands are level-sampled only in `IDLE`. Input changes during `EXECUTE`/`RESPOND` are ignored. A command still held on return to `IDLE` is accepted again as a new operation.
- Arithmetic is modulo 2^32 on the captured operands:
  - `ADD`: data = data1+data2. Response is `OVERFLOW` if there is carry-out of bit 31, else `SUCCESS`.
  - `SUBTRACT`: data = data1-data2. Response is `OVERFLOW` if data1<data2 (unsigned borrow), else `SUCCESS`.
  - `SHIFT_LEFT`: data = data1 << data2[4:0], with response `SUCCESS`. If data2[31:5] != 0, data = 0 and response = `ERROR`.
- Banks share nothing. Simultaneous commands on all banks proceed fully in parallel.
- `output_packet[i].data` holds the last result until the next result or reset.

## Timing
- Reset values: every `output_packet[i].data` = 0, every `.response` = `NO_RESPONSE`, all FSMs `IDLE`, all counters 0.
- Acceptance at posedge N puts the result on `output_packet` after posedge N+L, where L is the command latency.
  - The response is non-`NO_RESPONSE` for exactly one cycle and returns to `NO_RESPONSE` after posedge N+L+1.
  - The earliest next acceptance on the same bank is posedge N+L+2.
- With L=1, the result is visible one cycle after acceptance.
- Reset asserted mid-operation aborts the operation. No response is ever emitted for the aborted command, and outputs go to reset values asynchronously.
- On reset release, the first posedge with `reset`=1 may accept a command.
- A `NO_COMMAND` in `IDLE` leaves all outputs unchanged.

## Structure
- Shared package `alu_pkg` contains:
  - `command_names_t`, `response_names_t`, `input_packet_t`, `output_packet_t`;
  - the bank state enum (`IDLE`, `EXECUTE`, `RESPOND`);
  - the data width constant (32).
- Sub-module `alu_bank`: one FSM + counter + operand registers + result logic, instantiated `NUM_BANKS` times via generate.
  - Latency parameters pass through.
- Top level is wiring only.

## Test plan
- Reset: pulse `reset`=0 mid-run → all four banks show data 0x00000000 and `NO_RESPONSE` immediately, with no later responses.
- Bank 0 `ADD` 0x00000005 + 0x00000007 accepted at posedge N → `SUCCESS`, data 0x0000000C for exactly the cycle after posedge N+2; `NO_RESPONSE` after N+3 with data held.
- Overflow cases:
  - `ADD` 0xFFFFFFFF + 0x00000002 → data 0x00000001, `OVERFLOW`.
  - `SUBTRACT` 0x00000003 − 0x00000005 → data 0xFFFFFFFE, `OVERFLOW`.
  - `SUBTRACT` 5−3 → 0x00000002, `SUCCESS`.
- Shift cases:
  - `SHIFT_LEFT` 0x00000001 by 0x0000001F → 0x80000000 `SUCCESS` after posedge N+4.
  - `SHIFT_LEFT` by 0x00000020 → data 0, `ERROR`.
- Parallel banks and operand capture:
  - All four banks issue different commands at the same posedge → each responds at its own latency with correct values.
  - Changing `data1` during `EXECUTE` does not alter the result.
  - A held command is re-executed at N+L+2.
- Reset mid-operation: `SHIFT_LEFT` accepted at N, reset asserted at N+2 and released at N+3 → no response pulse; `ADD` 1+1 issued at N+4 → 0x00000002 `SUCCESS` after N+6.
